// File: rtl/fb_ram_banked.sv
// Banked frame-buffer RAM with one write port, one read port, registered read-bank
// select, out-of-range rejection and a full-frame clear engine.
module fb_ram_banked #(
  parameter int unsigned DW      = 9,
  parameter int unsigned HRES    = 640,
  parameter int unsigned VRES    = 480,
  parameter int unsigned AW      = 19,
  parameter int unsigned BANK_AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_err,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam int unsigned NPIX       = HRES * VRES;
  localparam int unsigned BANK_DEPTH = 2 ** BANK_AW;
  localparam int unsigned NUM_BANKS  = (NPIX + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int unsigned BW         = (AW > BANK_AW) ? AW - BANK_AW : 1;
  localparam logic [AW:0]   NPIX_W   = (AW+1)'(NPIX);
  localparam logic [AW-1:0] LAST     = AW'(NPIX - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;
  logic          wr_err_q, wr_err_d;
  logic          rd_valid_q, rd_inr_q;
  logic [BW-1:0] rd_bank_q;

  logic          we, we_ok;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [BW-1:0] wbank, rbank;
  logic [BANK_AW-1:0] wlocal, rlocal;
  logic [DW-1:0] bank_rd [NUM_BANKS];
  logic [DW-1:0] rd_mux;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NPIX_W;
  endfunction

  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = (state_q == S_DONE);
  assign wr_ready = ~clr_busy;
  assign wr_err   = wr_err_q;
  assign rd_valid = rd_valid_q;

  // The clear engine takes over the single write port while busy.
  always_comb begin
    we     = clr_busy | wr_valid;
    waddr  = clr_busy ? cnt_q   : wr_addr;
    wdata  = clr_busy ? color_q : wr_data;
    we_ok  = we & in_range(waddr);
    wbank  = BW'(waddr >> BANK_AW);
    wlocal = waddr[BANK_AW-1:0];
    rbank  = BW'(rd_addr >> BANK_AW);
    rlocal = rd_addr[BANK_AW-1:0];
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DW-1:0] mem [BANK_DEPTH];
    logic [DW-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (we_ok && wbank == BW'(b)) mem[wlocal] <= wdata;
      if (rd_en) rd_q <= mem[rlocal];
    end
    assign bank_rd[b] = rd_q;
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++)
      if (rd_bank_q == BW'(b)) rd_mux = bank_rd[b];
    rd_data = (rd_valid_q && rd_inr_q) ? rd_mux : '0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    color_d  = color_q;
    wr_err_d = wr_valid & wr_ready & ~in_range(wr_addr);
    case (state_q)
      S_IDLE: if (clr_start) begin
        state_d = S_CLEAR;
        cnt_d   = '0;
        color_d = clr_color;
      end
      S_CLEAR: begin
        if (cnt_q == LAST) state_d = S_DONE;
        else               cnt_d   = cnt_q + AW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      color_q    <= '0;
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_inr_q   <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      wr_err_q   <= wr_err_d;
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_inr_q  <= in_range(rd_addr);
        rd_bank_q <= rbank;
      end
    end
  end

endmodule

// File: tb/tb_fb_ram_banked.sv
// Directed, table-driven bench for fb_ram_banked: small 8x6 instance plus a default-size
// instance for the top-of-frame boundary.
module tb_fb_ram_banked;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       wr_valid, wr_ready, wr_err, rd_en, rd_valid;
  logic       clr_start, clr_busy, clr_done;
  logic [5:0] wr_addr, rd_addr;
  logic [8:0] wr_data, rd_data, clr_color;

  logic        b_wr_valid, b_wr_ready, b_wr_err, b_rd_en, b_rd_valid;
  logic        b_clr_start, b_clr_busy, b_clr_done;
  logic [18:0] b_wr_addr, b_rd_addr;
  logic [8:0]  b_wr_data, b_rd_data, b_clr_color;

  fb_ram_banked #(.DW(9), .HRES(8), .VRES(6), .AW(6), .BANK_AW(4)) u_dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  fb_ram_banked u_big (
    .clk(clk), .reset(reset),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_err(b_wr_err), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .clr_start(b_clr_start), .clr_color(b_clr_color),
    .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  typedef struct {
    logic       we;
    logic [5:0] wa;
    logic [8:0] wd;
    logic       re;
    logic [5:0] ra;
    logic       ev;
    logic [8:0] ed;
    logic       ee;
  } vec_t;

  vec_t vt[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t W(input logic [5:0] a, input logic [8:0] d, input logic ee);
    return '{1'b1, a, d, 1'b0, 6'd0, 1'b0, 9'd0, ee};
  endfunction
  function automatic vec_t R(input logic [5:0] a, input logic [8:0] ed);
    return '{1'b0, 6'd0, 9'd0, 1'b1, a, 1'b1, ed, 1'b0};
  endfunction
  function automatic vec_t WR(input logic [5:0] a, input logic [8:0] d, input logic [8:0] ed);
    return '{1'b1, a, d, 1'b1, a, 1'b1, ed, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_valid = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (clr_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(name, clr_done, 1);
  endtask

  task automatic write_px(input logic [5:0] a, input logic [8:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [5:0] a, input logic [8:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk($sformatf("%s[%0d]", name, a), rd_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt, done_cnt, done_cyc, rdy_bad;
    reset = 1'b1;
    idle_in();
    wr_addr = '0; wr_data = '0; rd_addr = '0; clr_color = '0;
    b_wr_valid = 1'b0; b_rd_en = 1'b0; b_clr_start = 1'b0;
    b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0; b_clr_color = '0;
    tick();
    tick();
    chk("reset wr_ready", wr_ready, 1);
    chk("reset wr_err",   wr_err,   0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_data",  rd_data,  0);
    chk("reset clr_busy", clr_busy, 0);
    chk("reset clr_done", clr_done, 0);
    reset = 1'b0;

    vt.push_back(W(6'd15, 9'h1A5, 1'b0));
    vt.push_back(W(6'd16, 9'h0C3, 1'b0));
    vt.push_back(W(6'd47, 9'h1FF, 1'b0));
    vt.push_back(R(6'd15, 9'h1A5));
    vt.push_back(R(6'd16, 9'h0C3));
    vt.push_back(R(6'd47, 9'h1FF));
    vt.push_back(W(6'd0,  9'h077, 1'b0));
    vt.push_back(W(6'd48, 9'h155, 1'b1));
    vt.push_back(R(6'd0,  9'h077));
    vt.push_back(R(6'd48, 9'h000));
    vt.push_back(R(6'd63, 9'h000));
    vt.push_back(W(6'd32, 9'h0B2, 1'b0));
    for (int k = 0; k < 3; k++) begin
      vt.push_back(R(6'd15, 9'h1A5));
      vt.push_back(R(6'd32, 9'h0B2));
    end
    vt.push_back(W(6'd20, 9'h100, 1'b0));
    vt.push_back(WR(6'd20, 9'h111, 9'h100));
    vt.push_back(R(6'd20, 9'h111));

    for (int i = 0; i < vt.size(); i++) begin
      wr_valid = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rd_en    = vt[i].re; rd_addr = vt[i].ra;
      tick();
      chk($sformatf("vec%0d rd_valid", i), rd_valid, vt[i].ev);
      chk($sformatf("vec%0d rd_data", i),  rd_data,  vt[i].ed);
      chk($sformatf("vec%0d wr_err", i),   wr_err,   vt[i].ee);
    end
    idle_in();

    // Full clear with a second clr_start and a user write attempted mid-clear
    clr_color = 9'h0AA; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; rdy_bad = 0;
    for (int c = 1; c <= 60; c++) begin
      if (clr_busy === 1'b1) busy_cnt++;
      if (wr_ready !== ~clr_busy) rdy_bad++;
      if (clr_done === 1'b1) begin done_cnt++; done_cyc = c; end
      clr_start = (c == 10);
      clr_color = (c == 10) ? 9'h155 : 9'h0AA;
      wr_valid  = (c == 12);
      wr_addr   = 6'd3; wr_data = 9'h1FF;
      tick();
    end
    idle_in();
    chk("clear busy cycles", busy_cnt, 48);
    chk("clear done cycle",  done_cyc, 49);
    chk("clear done pulses", done_cnt, 1);
    chk("clear wr_ready",    rdy_bad,  0);
    for (int a = 0; a < 48; a++) read_chk("clear readback", 6'(a), 9'h0AA);

    // Write and clr_start in the same idle cycle: write lands, then gets cleared
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 9'h001;
    clr_start = 1'b1; clr_color = 9'h033;
    chk("simul wr_ready", wr_ready, 1);
    tick();
    idle_in();
    wait_done("simul clr_done");
    tick();
    read_chk("simul readback", 6'd5, 9'h033);
    read_chk("simul readback", 6'd6, 9'h033);

    // Reset in clear cycle 20
    for (int a = 0; a < 48; a++) write_px(6'(a), 9'(a + 'h100));
    clr_color = 9'h0F0; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (19) tick();
    chk("midreset busy before", clr_busy, 1);
    reset = 1'b1;
    tick();
    chk("midreset busy",     clr_busy, 0);
    chk("midreset done",     clr_done, 0);
    chk("midreset wr_ready", wr_ready, 1);
    reset = 1'b0;
    tick();
    chk("midreset done after", clr_done, 0);
    chk("midreset busy after", clr_busy, 0);
    for (int a = 0; a <= 18; a++) read_chk("midreset cleared", 6'(a), 9'h0F0);
    for (int a = 20; a < 48; a++) read_chk("midreset kept", 6'(a), 9'(a + 'h100));

    // Default-size instance: last pixel and first out-of-range address
    b_wr_valid = 1'b1; b_wr_addr = 19'd307199; b_wr_data = 9'h123;
    tick();
    b_wr_valid = 1'b0;
    chk("big wr_err last", b_wr_err, 0);
    b_rd_en = 1'b1; b_rd_addr = 19'd307199;
    tick();
    b_rd_en = 1'b0;
    chk("big rd_valid", b_rd_valid, 1);
    chk("big rd_data",  b_rd_data,  9'h123);
    b_wr_valid = 1'b1; b_wr_addr = 19'd307200; b_wr_data = 9'h0AB;
    tick();
    b_wr_valid = 1'b0;
    chk("big wr_err oor", b_wr_err, 1);
    b_rd_en = 1'b1; b_rd_addr = 19'd307200;
    tick();
    b_rd_en = 1'b0;
    chk("big wr_err pulse", b_wr_err, 0);
    chk("big oor rd_valid", b_rd_valid, 1);
    chk("big oor rd_data",  b_rd_data,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_ram_banked.md
# fb_ram_banked

Parametrised VGA frame-buffer memory for the video subsystem's frame buffer core: one write port and one read port on a single clock. Storage is tiled from equal power-of-two banks of synchronous dual-port RAM sized to cover HRES*VRES pixels. Read-bank selection is registered, and out-of-range accesses are rejected. A built-in clear engine fills the whole frame with one colour.

## Interface
- DW, 9: pixel data width (colour depth).
- HRES, 640: horizontal pixels.
- VRES, 480: vertical pixels. NPIX = HRES*VRES (default 307,200).
- AW, 19: linear address width. Must satisfy 2^AW >= NPIX.
- BANK_AW, 16: address width of one bank. NUM_BANKS = ceil(NPIX / 2^BANK_AW) (default 5). Must satisfy BANK_AW <= AW.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_addr  in  AW  linear pixel address (y*HRES + x).
- wr_data  in  DW  pixel value.
- wr_err  out  1  one-cycle pulse: the previous accepted write was out of range.
- rd_en  in  1  read request; a read is accepted every cycle.
- rd_addr  in  AW  linear read address.
- rd_data  out  DW  read data; valid only when rd_valid = 1, otherwise 0.
- rd_valid  out  1  rd_data corresponds to the rd_en issued one cycle earlier.
- clr_start  in  1  start a frame clear; sampled only in IDLE.
- clr_color  in  DW  fill value; captured on the cycle clr_start is accepted.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

## Operation
- Address decode: bank = addr[AW-1:BANK_AW] and local = addr[BANK_AW-1:0].
  - An address is in range iff addr < NPIX.
  - Bank write enables are decoded from wr_addr only, never from rd_addr.
- Writes:
  - An accepted in-range write stores wr_data in exactly one bank.
  - An out-of-range write is accepted (the handshake completes), nothing is stored, and wr_err pulses.
- Reads:
  - The bank index and the in-range flag are registered alongside the BRAM read.
  - The output mux uses these registered copies, so rd_data always matches the address presented one cycle earlier.
  - Out-of-range reads return 0 with rd_valid = 1.
- Same-address read and write in the same cycle is read-first: the read returns the old data.
- Clear FSM states are IDLE, CLEAR and DONE.
  - IDLE -> CLEAR on clr_start. The counter loads 0 and clr_color is latched.
  - CLEAR writes the latched colour to address cnt every cycle, then increments cnt. When cnt = NPIX-1 is written, the FSM goes to DONE.
  - DONE -> IDLE unconditionally after one cycle. clr_done = 1 in DONE.
  - clr_busy = (state == CLEAR).
  - clr_start outside IDLE is ignored.
- wr_ready = ~clr_busy. User writes stall during a clear; the clear engine owns the write port.
- Reads are unaffected by a clear. They return whatever mix of old and cleared data is present.
- Counter width is AW. The counter never exceeds NPIX-1 and never wraps into unmapped bank space.

## Timing
- Reset values:
  - FSM state = IDLE, counter = 0.
  - wr_ready = 1, wr_err = 0, rd_valid = 0, rd_data = 0, clr_busy = 0, clr_done = 0.
  - RAM contents are not reset.
- Write latency: data is stored at the clock edge of acceptance and is readable by a read issued the next cycle.
- Read latency is 1 cycle.
  - rd_en at edge t gives rd_valid = 1 and rd_data at t+1.
  - Back-to-back reads give one result per cycle.
- wr_err is asserted in the cycle after the out-of-range write is accepted.
- Clear timing, with clr_start accepted at edge 0:
  - clr_busy is high for cycles 1..NPIX; address k is written at edge k+1.
  - clr_done is high in cycle NPIX+1, and wr_ready returns to 1 in that same cycle.
  - Total: NPIX+2 cycles from start to IDLE.
- clr_start and wr_valid in the same IDLE cycle: the write is accepted (wr_ready was 1), and the clear starts on the next cycle and overwrites it.
- Reset mid-clear: the FSM returns to IDLE, the counter goes to 0 and clr_done is not pulsed. Partially cleared memory is left as is.

## Test plan
- Small configuration (HRES=8, VRES=6, BANK_AW=4, AW=6, NPIX=48, 3 banks):
  - Write addr 15=0x1A5, 16=0x0C3, 47=0x1FF.
  - Read 15, 16, 47 back to back -> rd_data 0x1A5, 0x0C3, 0x1FF on consecutive cycles, rd_valid = 1 each time.
- Out of range:
  - Write addr 48 = 0x155 -> wr_err pulses for one cycle, addr 48 is not stored, and addr 0 is unchanged.
  - Read addr 63 -> rd_data = 0 with rd_valid = 1.
- Bank-select registration:
  - Alternate reads of addr 15 (bank 0) and addr 32 (bank 2) every cycle.
  - Each rd_data matches the address issued one cycle earlier; no cross-bank data appears.
- Clear:
  - clr_start with clr_color = 0x0AA -> clr_busy high for 48 cycles, wr_ready = 0 throughout, clr_done pulses at cycle 49.
  - A full readback of addresses 0..47 gives 0x0AA.
  - clr_start pulsed again mid-clear is ignored (still 48 busy cycles).
- Simultaneous events:
  - wr_valid to addr 5 = 0x001 together with clr_start -> the write is accepted, then cleared.
  - Read/write of the same address in one cycle returns the old value.
- Reset at clear cycle 20 -> clr_busy = 0 and clr_done = 0 next cycle. Addresses 0..18 hold the clear colour; addresses 20..47 keep their pre-clear data.
- Default configuration: write 307199 = 0x123 -> reads back 0x123 in bank 4. Write 307200 -> wr_err pulses.
